plugin_dispatch: RTL
====================

Name: plugin_dispatch

Overview:
- Issue/writeback controller between the RS5 execute stage and a start/busy/done handshake coprocessor plugin (e.g. the 32-bit adder plugin).
- Accepts one plugin request from the core, latches the operands and holds them stable, and pulses start.
- Waits for the plugin's done pulse, with a timeout watchdog, then presents the result as a held writeback until the core accepts it.
- Holds the core stalled while an operation is outstanding.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles in WAIT before abort; legal range >= 2.
- CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width; derived, do not override.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  core requests a plugin operation.
- req_ready  output  1  dispatcher can accept a request.
- req_rs1  input  32  operand A from the core.
- req_rs2  input  32  operand B from the core.
- req_rd  input  5  destination register index.
- stall  output  1  freeze core pipeline while an operation is in flight.
- plugin_start  output  1  start pulse to the plugin.
- plugin_operand_a  output  32  operand A to the plugin.
- plugin_operand_b  output  32  operand B to the plugin.
- plugin_busy  input  1  plugin busy; monitored only, not used for control.
- plugin_done  input  1  one-cycle completion pulse from the plugin.
- plugin_result  input  32  plugin result, valid when plugin_done=1.
- wb_valid  output  1  writeback data valid.
- wb_ready  input  1  core accepts writeback.
- wb_rd  output  5  writeback destination.
- wb_data  output  32  writeback value.
- wb_err  output  1  operation aborted by timeout.

Behaviour:
- Reset (async, immediate, any state):
  - State=IDLE; all latches and the counter cleared.
  - Outputs: req_ready=1, stall=0, plugin_start=0, plugin_operand_a/b=0, wb_valid=0, wb_rd=0, wb_data=0, wb_err=0.
  - Reset mid-operation drops the operation silently; nothing is written back.
- FSM states: IDLE, ISSUE, WAIT, WB. All outputs are Moore, decoded from state and registers. No combinational path from any input to any output, except that req_ready is a pure state decode.
- IDLE:
  - req_ready=1, stall=0.
  - On req_valid: latch rs1, rs2, rd into op_a, op_b, rd_q; go to ISSUE.
  - plugin_done in IDLE is ignored.
- ISSUE (exactly 1 cycle):
  - plugin_start=1; plugin_operand_a/b = op_a/op_b.
  - Counter cleared to 0; go to WAIT.
- WAIT:
  - plugin_start=0; operands stay driven and stable.
  - Counter increments by 1 per cycle.
  - If plugin_done=1: capture plugin_result into res_q, clear err_q, go to WB.
  - Else if counter == TIMEOUT_CYCLES-1: res_q=0, err_q=1, go to WB.
  - plugin_done and timeout in the same cycle: plugin_done wins; err_q=0 and the result is captured.
- WB:
  - wb_valid=1; wb_rd=rd_q, wb_data=res_q, wb_err=err_q, all held stable until wb_ready=1.
  - On wb_ready: go to IDLE. wb_valid drops the next cycle.
  - rd_q==0: still handshakes, but wb_data is forced to 0.
- stall = 1 in ISSUE, WAIT and WB; 0 in IDLE.
- req_ready = (state==IDLE). A req_valid held outside IDLE is not accepted; the core keeps it asserted.
- Back-to-back: a new request is accepted in the first IDLE cycle after the WB handshake, i.e. at most one operation in flight. No request is accepted in the same cycle as wb_ready.
- Latency: request accepted at cycle 0, start at cycle 1. If done arrives at cycle k, wb_valid rises at cycle k+1.
- Operand and result widths are fixed at 32; the dispatcher performs no arithmetic on data.

Test Plan:
1. Basic add:
   - Stimulus: req rs1=0x0000_0005, rs2=0x0000_0007, rd=3; plugin model pulses done 4 cycles after start with result 0x0000_000C; wb_ready=1.
   - Response: start high exactly on cycle 1, wb_valid on cycle 6 with wb_rd=3, wb_data=0x0000_000C, wb_err=0; stall high cycles 1..6.
2. Wraparound and backpressure:
   - Stimulus: rs1=0xFFFF_FFFF, rs2=0x0000_0001, plugin result 0x0000_0000; wb_ready held low 5 cycles.
   - Response: wb_valid, wb_data=0 and wb_rd held constant for all 5 cycles; IDLE reached one cycle after wb_ready.
3. Timeout:
   - Stimulus: TIMEOUT_CYCLES=8, plugin never pulses done.
   - Response: 8 WAIT cycles, then wb_valid=1, wb_err=1, wb_data=0.
   - Repeat with done on the last WAIT cycle -> wb_err=0 and the result is captured.
4. Spurious and illegal inputs:
   - Stimulus: plugin_done pulsed in IDLE; req_valid held during WAIT with different operands.
   - Response: no state change in IDLE; the second request is accepted only after WB; plugin_operand_a/b unchanged throughout WAIT.
5. Reset mid-operation:
   - Stimulus: assert reset during WAIT, between clock edges.
   - Response: all outputs go to their reset values immediately, with no wb_valid afterwards; the next request completes normally.
6. rd=0 and back-to-back:
   - Stimulus: rd=0 with plugin result 0x1234_5678, then a second request on the cycle after the handshake.
   - Response: wb_data=0 on the first; the second is accepted with no extra idle cycle and produces a correct writeback.

Source files
------------

// File: rtl/plugin_dispatch_if.sv
// Bundle of the core-side request/writeback handshakes and the plugin-side
// start/busy/done handshake seen by the plugin dispatcher.
interface plugin_dispatch_if;
    // core request channel
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        stall;

    // plugin channel
    logic        plugin_start;
    logic [31:0] plugin_operand_a;
    logic [31:0] plugin_operand_b;
    logic        plugin_busy;
    logic        plugin_done;
    logic [31:0] plugin_result;

    // core writeback channel
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;

    // dispatcher side
    modport slave (
        input  req_valid, req_rs1, req_rs2, req_rd,
        input  plugin_busy, plugin_done, plugin_result,
        input  wb_ready,
        output req_ready, stall,
        output plugin_start, plugin_operand_a, plugin_operand_b,
        output wb_valid, wb_rd, wb_data, wb_err
    );

    // core + plugin side
    modport master (
        output req_valid, req_rs1, req_rs2, req_rd,
        output plugin_busy, plugin_done, plugin_result,
        output wb_ready,
        input  req_ready, stall,
        input  plugin_start, plugin_operand_a, plugin_operand_b,
        input  wb_valid, wb_rd, wb_data, wb_err
    );
endinterface

// File: rtl/plugin_dispatch.sv
// Issue/writeback controller between the execute stage and a start/done
// coprocessor plugin. One operation in flight at a time: operands are
// latched and held, start is pulsed once, done (or a timeout) ends the
// wait, and the result is held as a writeback until the core takes it.
module plugin_dispatch #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    plugin_dispatch_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        WB
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [4:0]         rd_q;
    logic [DATA_W-1:0]  res_q;
    logic               err_q;
    logic [CNT_W-1:0]   cnt;
    logic               timeout_hit;

    // Last WAIT cycle before the watchdog gives up.
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register; reset drops any outstanding operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; done takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid)                     state_nxt = ISSUE;
            ISSUE:                                          state_nxt = WAIT;
            WAIT:    if (bus.plugin_done || timeout_hit)    state_nxt = WB;
            WB:      if (bus.wb_ready)                      state_nxt = IDLE;
            default:                                        state_nxt = IDLE;
        endcase
    end

    // Operand/result latches and the WAIT watchdog counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a  <= '0;
            op_b  <= '0;
            rd_q  <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_a <= bus.req_rs1;
                        op_b <= bus.req_rs2;
                        rd_q <= bus.req_rd;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (bus.plugin_done) begin
                        res_q <= bus.plugin_result;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Moore outputs: everything decodes from state and registers only.
    // plugin_busy is informational; control relies solely on the done pulse.
    assign bus.req_ready        = (state == IDLE);
    assign bus.stall            = (state != IDLE);
    assign bus.plugin_start     = (state == ISSUE);
    assign bus.plugin_operand_a = op_a;
    assign bus.plugin_operand_b = op_b;
    assign bus.wb_valid         = (state == WB);
    assign bus.wb_rd            = (state == WB) ? rd_q : 5'd0;
    // x0 writes are architecturally discarded, so the data is zeroed.
    assign bus.wb_data          = (state == WB && rd_q != 5'd0) ? res_q : '0;
    assign bus.wb_err           = (state == WB) ? err_q : 1'b0;

endmodule
